// File: rtl/nabp_shift_accumulator_pkg.sv
// Shared NABP configuration for the shift accumulator slice.
// Default geometry, FSM encoding and output width helper.
package nabp_shift_accumulator_pkg;

  localparam int kDefAngleLength = 9;
  localparam int kDefAccuWidth   = 16;
  localparam int kDefAccuFrac    = 8;
  localparam int kDefNumLines    = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } state_t;

  function automatic int shift_width(
    input int accu_w,
    input int accu_f,
    input int lines
  );
    return accu_w - accu_f + $clog2(lines);
  endfunction

endpackage

// File: rtl/nabp_shift_accumulator_lut.sv
// Registered shifter LUT: per-angle slope, one cycle after angle.
// Angle code maps linearly onto a slope in [-1.0, 1.0).
module nabp_shift_accumulator_lut #(
  parameter int kAngleLength = 9,
  parameter int kAccuWidth   = 16,
  parameter int kAccuFrac    = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [kAngleLength-1:0]      angle,
  output logic signed [kAccuWidth-1:0] base
);

  localparam int kUp = kAccuFrac - (kAngleLength - 1);

  logic signed [31:0] centered;
  logic signed [31:0] scaled;

  assign centered = $signed({{(32-kAngleLength){1'b0}}, angle})
                  - (32'sd1 <<< (kAngleLength - 1));

  if (kUp >= 0) begin : g_up
    assign scaled = centered <<< kUp;
  end else begin : g_dn
    assign scaled = centered >>> (-kUp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base <= '0;
    end else begin
      base <= kAccuWidth'(scaled);
    end
  end

endmodule

// File: rtl/nabp_shift_accumulator.sv
// NABP shift accumulator: one angle in, kNumLines rounded
// integer shifts out over a valid/ready stream.
module nabp_shift_accumulator
  import nabp_shift_accumulator_pkg::*;
#(
  parameter int kAngleLength = kDefAngleLength,
  parameter int kAccuWidth   = kDefAccuWidth,
  parameter int kAccuFrac    = kDefAccuFrac,
  parameter int kNumLines    = kDefNumLines,
  parameter bit kUseLut      = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_valid,
  input  logic [kAngleLength-1:0]      start_angle,
  output logic                         start_ready,
  output logic [kAngleLength-1:0]      sh_angle,
  input  logic signed [kAccuWidth-1:0] sh_accu_base,
  output logic                         shift_valid,
  input  logic                         shift_ready,
  output logic signed [shift_width(kAccuWidth, kAccuFrac, kNumLines)-1:0]
                                       shift_value,
  output logic                         shift_last,
  output logic                         busy
);

  localparam int kLog  = $clog2(kNumLines);
  localparam int kCntW = (kLog > 0) ? kLog : 1;
  localparam int kAccW = kAccuWidth + kLog + 1;
  localparam int kShW  = shift_width(kAccuWidth, kAccuFrac, kNumLines);

  localparam logic signed [kAccW-1:0] kHalf =
    kAccW'(1) << (kAccuFrac - 1);
  localparam logic [kCntW-1:0] kLastCnt = kCntW'(kNumLines - 1);

  state_t                     state;
  logic signed [kAccW-1:0]    acc;
  logic signed [kAccW-1:0]    base;
  logic [kCntW-1:0]           cnt;
  logic signed [kAccuWidth-1:0] lut_base;
  logic signed [kAccuWidth-1:0] src;

  nabp_shift_accumulator_lut #(
    .kAngleLength (kAngleLength),
    .kAccuWidth   (kAccuWidth),
    .kAccuFrac    (kAccuFrac)
  ) u_lut (
    .clk     (clk),
    .reset_n (reset_n),
    .angle   (sh_angle),
    .base    (lut_base)
  );

  // External port lets a stub LUT drive the base in standalone test
  assign src = kUseLut ? lut_base : sh_accu_base;

  assign shift_value = kShW'(acc >>> kAccuFrac);
  assign shift_last  = shift_valid && (cnt == kLastCnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sh_angle    <= '0;
      acc         <= '0;
      base        <= '0;
      cnt         <= '0;
      shift_valid <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          start_ready <= 1'b1;
          if (start_valid && start_ready) begin
            sh_angle    <= start_angle;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          base        <= kAccW'(src);
          acc         <= kHalf;
          cnt         <= '0;
          shift_valid <= 1'b1;
          state       <= STREAM;
        end
        STREAM: begin
          if (shift_ready) begin
            acc <= acc + base;
            cnt <= cnt + kCntW'(1);
            if (shift_last) begin
              shift_valid <= 1'b0;
              busy        <= 1'b0;
              start_ready <= 1'b1;
              state       <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nabp_shift_accumulator.sv
// Directed bench for nabp_shift_accumulator with a stub LUT
// and a queue scoreboard checked by an independent monitor.
module tb_nabp_shift_accumulator;

  localparam int kNumLines = 4;
  localparam int kShW      = 16 - 8 + 2;

  typedef struct {
    int value;
    bit last;
  } exp_t;

  logic                   clk;
  logic                   reset_n;
  logic                   start_valid;
  logic [8:0]             start_angle;
  logic                   start_ready;
  logic [8:0]             sh_angle;
  logic signed [15:0]     sh_accu_base;
  logic                   shift_valid;
  logic                   shift_ready;
  logic signed [kShW-1:0] shift_value;
  logic                   shift_last;
  logic                   busy;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  nabp_shift_accumulator #(
    .kNumLines (kNumLines)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_angle  (start_angle),
    .start_ready  (start_ready),
    .sh_angle     (sh_angle),
    .sh_accu_base (sh_accu_base),
    .shift_valid  (shift_valid),
    .shift_ready  (shift_ready),
    .shift_value  (shift_value),
    .shift_last   (shift_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] stub(input logic [8:0] a);
    case (a)
      9'd1:    return 16'sh0100;
      9'd2:    return 16'sh0080;
      9'd3:    return 16'shFF00;
      default: return 16'sh7777;
    endcase
  endfunction

  // Stub LUT with a one-cycle registered result
  always @(posedge clk) sh_accu_base <= stub(sh_angle);

  always @(negedge clk) begin
    if (reset_n && shift_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got=%0d last=%0b required=none",
                 shift_value, shift_last);
      end else if (shift_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(shift_value) != e.value || shift_last != e.last) begin
          n_err++;
          $display("FAIL stream got=%0d/%0b required=%0d/%0b",
                   shift_value, shift_last, e.value, e.last);
        end
      end else begin
        if (int'(shift_value) != exp_q[0].value ||
            shift_last != exp_q[0].last) begin
          n_err++;
          $display("FAIL stall_hold got=%0d/%0b required=%0d/%0b",
                   shift_value, shift_last,
                   exp_q[0].value, exp_q[0].last);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic exp4(input int a, input int b, input int c, input int d);
    exp_q.push_back('{a, 1'b0});
    exp_q.push_back('{b, 1'b0});
    exp_q.push_back('{c, 1'b0});
    exp_q.push_back('{d, 1'b1});
  endtask

  // Ends at #1 after the edge where shift_valid first rises
  task automatic latency_check();
    check("lat_e0", int'(shift_valid), 0);
    @(posedge clk); #1;
    check("lat_e1", int'(shift_valid), 0);
    @(posedge clk); #1;
    check("lat_e2", int'(shift_valid), 1);
  endtask

  task automatic run_start(input logic [8:0] a);
    int n;
    n = 0;
    while (!start_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_ready_wait", int'(start_ready), 1);
    start_valid = 1'b1;
    start_angle = a;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("sh_angle_latch", int'(sh_angle), int'(a));
    latency_check();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    reset_n     = 1'b1;
    start_valid = 1'b0;
    start_angle = '0;
    shift_ready = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sh_angle", int'(sh_angle), 0);
    check("rst_start_ready", int'(start_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(shift_valid), 0);
    check("rst_last", int'(shift_last), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", int'(start_ready), 1);

    exp4(0, 1, 2, 3);
    run_start(9'd1);
    wait_idle();

    exp4(0, 1, 1, 2);
    run_start(9'd2);
    wait_idle();

    exp4(0, -1, -2, -3);
    run_start(9'd3);
    wait_idle();

    exp4(0, 1, 2, 3);
    run_start(9'd1);
    @(posedge clk); #1;
    shift_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 shift_ready = 1'b1;
    wait_idle();

    exp4(0, 1, 1, 2);
    run_start(9'd2);
    @(posedge clk); #1;
    start_valid = 1'b1;
    start_angle = 9'd4;
    check("stream_ready_low", int'(start_ready), 0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("stream_sh_angle", int'(sh_angle), 2);
    for (int i = 0; i < 10 && !shift_last; i++) begin
      @(posedge clk); #1;
    end
    check("saw_last", int'(shift_last), 1);
    exp4(0, -1, -2, -3);
    start_valid = 1'b1;
    start_angle = 9'd3;
    @(posedge clk); #1;
    check("ready_after_last", int'(start_ready), 1);
    check("idle_after_last", int'(busy), 0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("restart_busy", int'(busy), 1);
    check("restart_angle", int'(sh_angle), 3);
    latency_check();
    wait_idle();

    exp4(0, 1, 2, 3);
    run_start(9'd1);
    @(posedge clk); #1;
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_valid", int'(shift_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(start_ready), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_ready", int'(start_ready), 1);
    check("post_abort_busy", int'(busy), 0);
    check("post_abort_valid", int'(shift_valid), 0);
    check("post_abort_angle", int'(sh_angle), 0);
    repeat (6) @(posedge clk);
    #1;
    check("post_abort_quiet", int'(shift_valid), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
